// File: rtl/cpu_pkg.sv
// Shared constants and IF/ID record for the MIPS core.
// PC increment keeps the kernel bit and wraps within the low 31 bits.
package cpu_pkg;

   localparam logic [31:0] RESET_VEC  = 32'h8000_0000;
   localparam logic [31:0] IRQ_VEC    = 32'h8000_0004;
   localparam logic [31:0] EXC_VEC    = 32'h8000_0008;
   localparam int          KERNEL_BIT = 31;
   localparam logic [31:0] NOP        = 32'h0000_0000;

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc4;
   } ifid_t;

   function automatic logic [31:0] inc_pc(input logic [31:0] pc);
      return {pc[KERNEL_BIT], pc[KERNEL_BIT-1:0] + 31'd4};
   endfunction

endpackage

// File: rtl/pc_sel.sv
// Next-PC priority mux and interrupt eligibility; purely combinational.
// Stall only holds the PC when no exception, interrupt, redirect or jump wins.
module pc_sel
   import cpu_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic        id_valid_i,
   input  logic [3:0]  id_pc4_hi_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        jump_i,
   input  logic [25:0] jump_idx_i,
   input  logic        exc_i,
   input  logic        irq_i,
   output logic [31:0] pc4_o,
   output logic [31:0] next_pc_o,
   output logic        irq_take_o,
   output logic        kill_o
);

   logic [31:0] jump_tgt;

   assign pc4_o    = inc_pc(pc_i);
   assign jump_tgt = {id_pc4_hi_i, jump_idx_i, 2'b00};

   // Interrupts only land between real user instructions so EPC is meaningful.
   assign irq_take_o = irq_i && !pc_i[KERNEL_BIT] && id_valid_i &&
                       !exc_i && !redirect_i && !jump_i && !stall_i;

   assign kill_o = exc_i || irq_take_o || redirect_i || jump_i;

   always_comb begin
      next_pc_o = pc4_o;
      if (exc_i) begin
         next_pc_o = EXC_VEC;
      end else if (irq_take_o) begin
         next_pc_o = IRQ_VEC;
      end else if (redirect_i) begin
         next_pc_o = redirect_pc_i;
      end else if (jump_i) begin
         next_pc_o = jump_tgt;
      end else if (stall_i) begin
         next_pc_o = pc_i;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register plus IF/ID register, ROM word captured one edge after its address.
// Stall holds PC and IF/ID; flush or any control transfer loads a bubble.
module if_stage
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        jump,
   input  logic [25:0] jump_idx,
   input  logic        exc,
   input  logic        irq,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc4,
   output logic        irq_ack,
   output logic [31:0] epc
);

   logic [31:0] pc_q, pc_d;
   ifid_t       ifid_q, ifid_d;
   logic [31:0] pc4;
   logic        irq_take;
   logic        kill;

   pc_sel u_pc_sel (
      .pc_i          (pc_q),
      .id_valid_i    (ifid_q.valid),
      .id_pc4_hi_i   (ifid_q.pc4[31:28]),
      .stall_i       (stall),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .jump_i        (jump),
      .jump_idx_i    (jump_idx),
      .exc_i         (exc),
      .irq_i         (irq),
      .pc4_o         (pc4),
      .next_pc_o     (pc_d),
      .irq_take_o    (irq_take),
      .kill_o        (kill)
   );

   always_comb begin
      ifid_d = ifid_q;
      if (kill || flush) begin
         ifid_d = '{valid: 1'b0, instr: NOP, pc4: 32'h0};
      end else if (!stall) begin
         ifid_d = '{valid: 1'b1, instr: imem_data, pc4: pc4};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc_q   <= RESET_VEC;
         ifid_q <= '0;
      end else begin
         pc_q   <= pc_d;
         ifid_q <= ifid_d;
      end
   end

   assign imem_addr = pc_q;
   assign id_valid  = ifid_q.valid;
   assign id_instr  = ifid_q.instr;
   assign id_pc4    = ifid_q.pc4;
   // The squashed instruction at PC is re-executed by returning to epc-4.
   assign irq_ack   = irq_take && reset_n;
   assign epc       = pc4;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: each driven cycle pushes the expected PC and IF/ID contents,
// which are popped and compared after the clock edge.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        stall, flush, redirect, jump, exc, irq;
   logic [31:0] redirect_pc;
   logic [25:0] jump_idx;
   logic        id_valid;
   logic [31:0] id_instr, id_pc4;
   logic        irq_ack;
   logic [31:0] epc;

   always #5 clk = ~clk;

   if_stage dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .stall       (stall),
      .flush       (flush),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .jump        (jump),
      .jump_idx    (jump_idx),
      .exc         (exc),
      .irq         (irq),
      .id_valid    (id_valid),
      .id_instr    (id_instr),
      .id_pc4      (id_pc4),
      .irq_ack     (irq_ack),
      .epc         (epc)
   );

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      case (a)
         32'h8000_0000: rom_word = 32'h0800_0003;
         32'h8000_000C: rom_word = 32'h3c08_4000;
         default:       rom_word = ~a;
      endcase
   endfunction

   assign imem_data = rom_word(imem_addr);

   function automatic logic [31:0] inc4(input logic [31:0] a);
      return {a[31], a[30:0] + 31'd4};
   endfunction

   typedef struct packed {
      logic [31:0] pc;
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;

   localparam int LOAD   = 0;
   localparam int BUBBLE = 1;
   localparam int HOLD   = 2;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] cur_pc;
   logic        cur_v;
   logic [31:0] cur_instr, cur_pc4;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic [31:0] nxt, input int kind, input logic ack,
                      input logic [31:0] exp_epc);
      exp_t e;
      #1;
      chk("imem_addr", imem_addr, cur_pc);
      chk("irq_ack", {31'b0, irq_ack}, {31'b0, ack});
      if (ack) chk("epc", epc, exp_epc);
      e.pc = nxt;
      case (kind)
         LOAD: begin
            e.valid = 1'b1;
            e.instr = rom_word(cur_pc);
            e.pc4   = inc4(cur_pc);
         end
         BUBBLE: begin
            e.valid = 1'b0;
            e.instr = 32'h0;
            e.pc4   = 32'h0;
         end
         default: begin
            e.valid = cur_v;
            e.instr = cur_instr;
            e.pc4   = cur_pc4;
         end
      endcase
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'h1, 32'h0);
      end else begin
         e = sb.pop_front();
         chk("pc", imem_addr, e.pc);
         chk("id_valid", {31'b0, id_valid}, {31'b0, e.valid});
         chk("id_instr", id_instr, e.instr);
         chk("id_pc4", id_pc4, e.pc4);
         cur_pc    = e.pc;
         cur_v     = e.valid;
         cur_instr = e.instr;
         cur_pc4   = e.pc4;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; jump = 1'b0;
      exc = 1'b0; irq = 1'b0; redirect_pc = 32'h0; jump_idx = 26'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", imem_addr, 32'h8000_0000);
      chk("rst_valid", {31'b0, id_valid}, 32'h0);
      chk("rst_instr", id_instr, 32'h0);
      chk("rst_pc4", id_pc4, 32'h0);
      cur_pc = 32'h8000_0000; cur_v = 1'b0; cur_instr = 32'h0; cur_pc4 = 32'h0;
      reset_n = 1'b1;

      // First fetch of ROM word 0, then the jump it encodes.
      cyc(32'h8000_0004, LOAD, 1'b0, 32'h0);
      chk("rom0_instr", id_instr, 32'h0800_0003);
      jump = 1'b1; jump_idx = 26'd3;
      cyc(32'h8000_000C, BUBBLE, 1'b0, 32'h0);
      jump = 1'b0;
      cyc(32'h8000_0010, LOAD, 1'b0, 32'h0);
      chk("jump_tgt_instr", id_instr, 32'h3c08_4000);

      redirect = 1'b1; redirect_pc = 32'h0000_0040;
      cyc(32'h0000_0040, BUBBLE, 1'b0, 32'h0);
      redirect = 1'b0;
      stall = 1'b1;
      repeat (3) cyc(32'h0000_0040, HOLD, 1'b0, 32'h0);
      stall = 1'b0;
      cyc(32'h0000_0044, LOAD, 1'b0, 32'h0);
      for (int a = 32'h44; a <= 32'h54; a += 4) cyc(a + 4, LOAD, 1'b0, 32'h0);

      // User-mode interrupt, then irq held high while in kernel mode.
      irq = 1'b1;
      cyc(32'h8000_0004, BUBBLE, 1'b1, 32'h0000_005C);
      cyc(32'h8000_0008, LOAD, 1'b0, 32'h0);
      cyc(32'h8000_000C, LOAD, 1'b0, 32'h0);
      irq = 1'b0;

      flush = 1'b1;
      cyc(32'h8000_0010, BUBBLE, 1'b0, 32'h0);
      stall = 1'b1;
      cyc(32'h8000_0010, BUBBLE, 1'b0, 32'h0);
      stall = 1'b0; flush = 1'b0;

      // Priority: exc over redirect over irq, then deferred irq is taken in user mode.
      redirect = 1'b1; redirect_pc = 32'h0000_0100;
      cyc(32'h0000_0100, BUBBLE, 1'b0, 32'h0);
      redirect = 1'b0;
      cyc(32'h0000_0104, LOAD, 1'b0, 32'h0);
      exc = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0020; irq = 1'b1;
      cyc(32'h8000_0008, BUBBLE, 1'b0, 32'h0);
      exc = 1'b0; redirect = 1'b0;
      cyc(32'h8000_000C, LOAD, 1'b0, 32'h0);
      redirect = 1'b1;
      cyc(32'h0000_0020, BUBBLE, 1'b0, 32'h0);
      redirect = 1'b0;
      cyc(32'h0000_0024, LOAD, 1'b0, 32'h0);
      cyc(32'h8000_0004, BUBBLE, 1'b1, 32'h0000_0028);
      irq = 1'b0;

      // 31-bit wrap in user space.
      redirect = 1'b1; redirect_pc = 32'h7FFF_FFFC;
      cyc(32'h7FFF_FFFC, BUBBLE, 1'b0, 32'h0);
      redirect = 1'b0;
      cyc(32'h0000_0000, LOAD, 1'b0, 32'h0);

      // Reset mid-run with an otherwise eligible interrupt pending.
      reset_n = 1'b0; irq = 1'b1;
      cyc(32'h8000_0000, BUBBLE, 1'b0, 32'h0);
      reset_n = 1'b1; irq = 1'b0;
      cyc(32'h8000_0004, LOAD, 1'b0, 32'h0);

      // Wrap in kernel space keeps the kernel bit.
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      cyc(32'hFFFF_FFFC, BUBBLE, 1'b0, 32'h0);
      redirect = 1'b0;
      cyc(32'h8000_0000, LOAD, 1'b0, 32'h0);
      chk("kwrap_pc4", id_pc4, 32'h8000_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the MIPS core: owns the program counter, drives the combinational instruction ROM address, and registers the returned word into the IF/ID pipeline register. It applies the next-PC priority (exception, interrupt, late redirect, jump, sequential), handles stall and flush from the hazard unit, and preserves the kernel bit PC[31]. It sits between the hazard/branch logic and the decode stage.

## Interface
- RESET_VEC, 32'h8000_0000, PC after reset (kernel mode, ROM word 0)
- IRQ_VEC, 32'h8000_0004, interrupt entry (ROM word 1)
- EXC_VEC, 32'h8000_0008, exception entry (ROM word 2)

- clk  in  1  single clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- imem_addr  out  32  to instruction ROM; equals PC
- imem_data  in  32  ROM word (combinational, same cycle)
- stall  in  1  hold PC and IF/ID
- flush  in  1  load bubble into IF/ID
- redirect  in  1  branch/jr resolved taken (from EX)
- redirect_pc  in  32  target for redirect
- jump  in  1  J/JAL decoded in ID
- jump_idx  in  26  instr[25:0] of the jump in ID
- exc  in  1  undefined instruction detected in ID
- irq  in  1  level interrupt request (timer)
- id_valid  out  1  IF/ID holds a real instruction
- id_instr  out  32  IF/ID instruction (0 = nop when invalid)
- id_pc4  out  32  IF/ID PC+4
- irq_ack  out  1  one-cycle pulse: interrupt taken
- epc  out  32  return value for $26, valid with irq_ack

## Operation
- pc4 = {PC[31], PC[30:0]+4}; PC[31] never changes via increment (31-bit wrap, kernel bit kept).
- Jump target = {id_pc4[31:28], jump_idx, 2'b00}.
- irq eligible only when PC[31]==0, id_valid==1, and no exc/redirect/jump/stall this cycle; otherwise deferred (irq is level).
- Next-PC priority: exc → EXC_VEC; irq eligible → IRQ_VEC; redirect → redirect_pc; jump → jump target; stall → PC; else pc4.
- IF/ID update priority: exc, irq taken, redirect, jump, or flush → bubble (valid 0, instr 0, pc4 0); else stall → hold; else {1, imem_data, pc4}.
- Interrupt taken: irq_ack=1 that cycle, epc = PC+4 with PC[31] kept (instruction at PC is squashed; handler subtracts 4 and returns via jr $26).
- exc and redirect override stall; PC still loads the target.

## Timing
- Reset (reset_n==0 at edge): PC=RESET_VEC, id_valid=0, id_instr=0, id_pc4=0; irq_ack=0 combinationally whenever reset_n==0. Reset mid-operation discards all pending state in one edge.
- imem_addr = PC combinationally; ROM word captured into IF/ID at next edge; fetch latency 1 cycle.
- Redirect/jump/exc/irq: new PC at next edge, first target instruction in IF/ID one edge later; exactly one bubble per jump, one per redirect (older wrong-path word in ID is flushed by hazard unit via flush).
- irq_ack and epc are combinational, same cycle the PC selects IRQ_VEC.
- stall+flush same cycle: bubble in IF/ID, PC held.

## Structure
- Shared package cpu_pkg: RESET_VEC, IRQ_VEC, EXC_VEC, KERNEL_BIT=31, NOP=32'h0.
- One sub-module: pc_sel (combinational next-PC priority mux plus irq eligibility); if_stage holds PC and IF/ID registers.

## Test plan
- Reset: reset_n low 2 cycles → imem_addr=0x80000000, id_valid=0; release → id_instr=ROM[0] (0x08000003) after one edge, id_pc4=0x80000004.
- Jump: jump=1, jump_idx=3, id_pc4=0x80000004 → next PC=0x8000000C, one bubble, then id_instr=0x3c084000.
- Stall: PC=0x00000040, stall 3 cycles → PC and IF/ID unchanged; release → PC=0x00000044.
- Interrupt user mode: PC=0x00000058, irq=1 → irq_ack=1, epc=0x0000005C, next PC=0x80000004, IF/ID bubble; irq held in kernel mode → no second ack.
- Priority: exc, redirect (0x00000020) and irq same cycle → PC=0x80000008, no irq_ack; next user cycle with irq still high → ack.
- Wrap: PC=0x7FFFFFFC sequential → 0x00000000; PC=0xFFFFFFFC → 0x80000000.
